bet_capture: RTL and testbench

Upstream of the register file's bet inputs. Consumes per-byte strobes from the PS/2 controller, the decoded bet opcode and the chip colour. It filters PS/2 break sequences, packs accepted bets into a fixed table of up to MAX_BETS entries, and sequences the round (collect, spin, result hold). The packed table, the bet count and the spin request feed the regfile and processor. This replaces ad-hoc counter/case latching.

---
 rtl/bet_pkg.sv | 24 ++
 rtl/ps2_make_filter.sv | 33 +++
 rtl/bet_capture.sv | 163 ++++++++++++++++
 tb/tb_bet_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bet_pkg.sv
// Shared constants and types for the bet capture path: opcode values
// produced by keyboardToBet, PS/2 prefix bytes and the round state enum.
package bet_pkg;

    // Width of one packed table entry: {chip_color[1:0], opcode[5:0]}
    localparam int ENTRY_W = 8;

    // Special opcodes from the keyboard decoder
    localparam logic [5:0] OP_SPIN  = 6'b111110;
    localparam logic [5:0] OP_NONE  = 6'b111111;
    localparam logic [5:0] OP_CLEAR = 6'b111101;

    // PS/2 prefix bytes
    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;

    // Round sequencing states
    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_SPINNING = 2'd1,
        ST_DONE     = 2'd2
    } round_state_t;

endpackage

// File: rtl/ps2_make_filter.sv
// Turns the raw PS/2 byte stream into one-cycle key events for make codes
// only. A break prefix (F0) swallows itself and the byte that follows it;
// the extended prefix (E0) is dropped without disturbing the break tracking.
module ps2_make_filter
    import bet_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       key_event
);

    logic break_flag;

    // Remember a pending break prefix until the next received byte consumes it
    always_ff @(posedge clock) begin
        if (reset) begin
            break_flag <= 1'b0;
        end else if (rx_valid) begin
            if (break_flag) begin
                break_flag <= 1'b0;
            end else if (rx_byte == KEY_BREAK) begin
                break_flag <= 1'b1;
            end
        end
    end

    // A make code is any byte that is neither a prefix nor the released key
    assign key_event = rx_valid && !break_flag &&
                       (rx_byte != KEY_BREAK) && (rx_byte != KEY_EXT);

endmodule

// File: rtl/bet_capture.sv
// Collects bets from the keyboard into a packed table, then sequences the
// round: collect bets, spin the wheel, hold the result until the next bet
// or clear starts a new round.
module bet_capture
    import bet_pkg::*;
#(
    parameter int MAX_BETS = 12,
    parameter int CNT_W    = 4
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    input  logic [5:0]                  bet_opcode,
    input  logic [2:0]                  chip_color,
    input  logic                        spin_done,
    output logic [ENTRY_W*MAX_BETS-1:0] bets,
    output logic [CNT_W-1:0]            bet_count,
    output logic                        spin_start,
    output logic                        spinning,
    output logic                        bet_accept,
    output logic                        bet_reject,
    output logic                        table_full
);

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_BETS);

    round_state_t                state_r;
    round_state_t                state_next;
    logic [ENTRY_W*MAX_BETS-1:0] bets_r;
    logic [ENTRY_W*MAX_BETS-1:0] bets_next;
    logic [CNT_W-1:0]            count_r;
    logic [CNT_W-1:0]            count_next;
    logic                        accept_next;
    logic                        reject_next;
    logic                        start_next;
    logic                        spin_start_r;
    logic                        spinning_r;
    logic                        accept_r;
    logic                        reject_r;
    logic                        full_r;

    logic                        key_event;
    logic                        is_spin;
    logic                        is_clear;
    logic                        is_bet;
    logic                        color_ok;
    logic [ENTRY_W-1:0]          new_entry;

    ps2_make_filter u_filter (
        .clock     (clock),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .key_event (key_event)
    );

    assign is_spin   = (bet_opcode == OP_SPIN);
    assign is_clear  = (bet_opcode == OP_CLEAR);
    assign is_bet    = (bet_opcode != OP_NONE) && !is_spin && !is_clear;
    assign color_ok  = (chip_color != 3'b000);
    assign new_entry = {chip_color[1:0], bet_opcode};

    // Register the round state, the table and every output pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_COLLECT;
            bets_r       <= '0;
            count_r      <= '0;
            spin_start_r <= 1'b0;
            spinning_r   <= 1'b0;
            accept_r     <= 1'b0;
            reject_r     <= 1'b0;
            full_r       <= 1'b0;
        end else begin
            state_r      <= state_next;
            bets_r       <= bets_next;
            count_r      <= count_next;
            spin_start_r <= start_next;
            spinning_r   <= (state_next == ST_SPINNING);
            accept_r     <= accept_next;
            reject_r     <= reject_next;
            full_r       <= (count_next == MAX_COUNT);
        end
    end

    // Decide how the current key event and spin_done change the round
    always_comb begin
        state_next  = state_r;
        bets_next   = bets_r;
        count_next  = count_r;
        accept_next = 1'b0;
        reject_next = 1'b0;
        start_next  = 1'b0;

        case (state_r)
            ST_COLLECT: begin
                if (key_event) begin
                    if (is_bet) begin
                        if (color_ok && (count_r < MAX_COUNT)) begin
                            for (int i = 0; i < MAX_BETS; i++) begin
                                if (count_r == CNT_W'(i)) begin
                                    bets_next[i*ENTRY_W +: ENTRY_W] = new_entry;
                                end
                            end
                            count_next  = count_r + CNT_W'(1);
                            accept_next = 1'b1;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end else if (is_spin) begin
                        if (count_r != '0) begin
                            state_next = ST_SPINNING;
                            start_next = 1'b1;
                        end
                    end else if (is_clear) begin
                        bets_next  = '0;
                        count_next = '0;
                    end
                end
            end

            ST_SPINNING: begin
                if (spin_done) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                if (key_event) begin
                    if (is_clear) begin
                        bets_next  = '0;
                        count_next = '0;
                        state_next = ST_COLLECT;
                    end else if (is_bet) begin
                        if (color_ok) begin
                            bets_next                = '0;
                            bets_next[ENTRY_W-1:0]   = new_entry;
                            count_next               = CNT_W'(1);
                            accept_next              = 1'b1;
                            state_next               = ST_COLLECT;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    assign bets       = bets_r;
    assign bet_count  = count_r;
    assign spin_start = spin_start_r;
    assign spinning   = spinning_r;
    assign bet_accept = accept_r;
    assign bet_reject = reject_r;
    assign table_full = full_r;

endmodule

// File: tb/tb_bet_capture.sv
// Self-checking bench for bet_capture: directed round scenarios followed by
// randomized keyboard traffic, all compared against a queue-based model.
module tb_bet_capture;

    localparam int MAX_BETS = 12;
    localparam int CNT_W    = 4;

    localparam logic [5:0] OP_SPIN  = 6'b111110;
    localparam logic [5:0] OP_NONE  = 6'b111111;
    localparam logic [5:0] OP_CLEAR = 6'b111101;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  rx_valid = 1'b0;
    logic [7:0]            rx_byte = 8'h00;
    logic [5:0]            bet_opcode = 6'd0;
    logic [2:0]            chip_color = 3'd0;
    logic                  spin_done = 1'b0;
    logic [8*MAX_BETS-1:0] bets;
    logic [CNT_W-1:0]      bet_count;
    logic                  spin_start;
    logic                  spinning;
    logic                  bet_accept;
    logic                  bet_reject;
    logic                  table_full;

    int errors = 0;
    int checks = 0;

    // Reference model: the table is a plain queue of stored entries
    logic [7:0] m_table[$];
    int         m_phase = 0;    // 0 = taking bets, 1 = wheel turning, 2 = showing result
    bit         m_brk = 1'b0;
    bit         m_accept = 1'b0;
    bit         m_reject = 1'b0;
    bit         m_start = 1'b0;

    bet_capture #(.MAX_BETS(MAX_BETS), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .bet_opcode (bet_opcode),
        .chip_color (chip_color),
        .spin_done  (spin_done),
        .bets       (bets),
        .bet_count  (bet_count),
        .spin_start (spin_start),
        .spinning   (spinning),
        .bet_accept (bet_accept),
        .bet_reject (bet_reject),
        .table_full (table_full)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs of that cycle
    task automatic modelStep(input bit rst, input bit rxv, input logic [7:0] b,
                             input logic [5:0] op, input logic [2:0] col, input bit done);
        bit key;
        bit bet;
        m_accept = 1'b0;
        m_reject = 1'b0;
        m_start  = 1'b0;
        if (rst) begin
            m_table.delete();
            m_phase = 0;
            m_brk   = 1'b0;
            return;
        end
        key = 1'b0;
        if (rxv) begin
            if (m_brk) m_brk = 1'b0;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) key = 1'b1;
        end
        bet = (op != OP_NONE) && (op != OP_SPIN) && (op != OP_CLEAR);
        if (m_phase == 0) begin
            if (key) begin
                if (bet) begin
                    if (col != 0 && m_table.size() < MAX_BETS) begin
                        m_table.push_back({col[1:0], op});
                        m_accept = 1'b1;
                    end else begin
                        m_reject = 1'b1;
                    end
                end else if (op == OP_SPIN && m_table.size() > 0) begin
                    m_phase = 1;
                    m_start = 1'b1;
                end else if (op == OP_CLEAR) begin
                    m_table.delete();
                end
            end
        end else if (m_phase == 1) begin
            if (done) m_phase = 2;
        end else begin
            if (key) begin
                if (op == OP_CLEAR) begin
                    m_table.delete();
                    m_phase = 0;
                end else if (bet) begin
                    if (col != 0) begin
                        m_table.delete();
                        m_table.push_back({col[1:0], op});
                        m_accept = 1'b1;
                        m_phase  = 0;
                    end else begin
                        m_reject = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic checkAll();
        logic [95:0] exp_bets;
        exp_bets = '0;
        foreach (m_table[i]) exp_bets[i*8 +: 8] = m_table[i];
        checkOutput("bets", bets, exp_bets);
        checkOutput("bet_count", bet_count, m_table.size());
        checkOutput("bet_accept", bet_accept, m_accept);
        checkOutput("bet_reject", bet_reject, m_reject);
        checkOutput("spin_start", spin_start, m_start);
        checkOutput("spinning", spinning, m_phase == 1);
        checkOutput("table_full", table_full, m_table.size() == MAX_BETS);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare
    task automatic applyStimulus(input bit rst, input bit rxv, input logic [7:0] b,
                                 input logic [5:0] op, input logic [2:0] col, input bit done);
        @(negedge clock);
        reset      = rst;
        rx_valid   = rxv;
        rx_byte    = b;
        bet_opcode = op;
        chip_color = col;
        spin_done  = done;
        @(posedge clock);
        modelStep(rst, rxv, b, op, col, done);
        #1;
        checkAll();
    endtask

    task automatic pressKey(input logic [5:0] op, input logic [2:0] col);
        applyStimulus(1'b0, 1'b1, 8'h16, op, col, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'h00, OP_NONE, 3'd0, 1'b0);
    endtask

    initial begin
        logic [7:0]  rb;
        logic [5:0]  rop;
        logic [2:0]  rcol;
        int          sel;

        // Reset state
        applyStimulus(1'b1, 1'b0, 8'h00, OP_NONE, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, OP_NONE, 3'd0, 1'b0);
        checkOutput("reset_count", bet_count, 4'd0);

        // First bet lands in entry 0 as {colour[1:0], opcode}
        pressKey(6'd1, 3'b101);
        checkOutput("first_entry", bets[7:0], 8'h41);
        checkOutput("first_accept", bet_accept, 1'b1);
        idle();
        checkOutput("accept_one_cycle", bet_accept, 1'b0);

        // Key release sequence stores nothing more
        applyStimulus(1'b0, 1'b1, 8'hF0, 6'd1, 3'b101, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h16, 6'd1, 3'b101, 1'b0);
        checkOutput("release_count", bet_count, 4'd1);
        checkOutput("release_no_reject", bet_reject, 1'b0);

        // Fill the table, then overflow it
        for (int i = 0; i < MAX_BETS - 1; i++) pressKey(6'(i + 2), 3'(1 + (i % 7)));
        checkOutput("full_flag", table_full, 1'b1);
        pressKey(6'd40, 3'b011);
        checkOutput("overflow_reject", bet_reject, 1'b1);
        checkOutput("entry11_kept", bets[95:88], {2'(1 + (10 % 7)), 6'd12});

        // Clear, spin on an empty table, then a real spin
        pressKey(OP_CLEAR, 3'd0);
        checkOutput("clear_count", bet_count, 4'd0);
        pressKey(OP_SPIN, 3'd0);
        checkOutput("empty_spin", spinning, 1'b0);
        pressKey(6'd3, 3'b001);
        pressKey(6'd4, 3'b010);
        pressKey(6'd5, 3'b011);
        pressKey(OP_SPIN, 3'd0);
        checkOutput("spin_start", spin_start, 1'b1);
        checkOutput("spin_active", spinning, 1'b1);
        pressKey(6'd7, 3'b001);
        checkOutput("spin_drop_count", bet_count, 4'd3);

        // spin_done wins over a coincident bet
        applyStimulus(1'b0, 1'b1, 8'h1C, 6'd9, 3'b010, 1'b1);
        checkOutput("done_no_accept", bet_accept, 1'b0);
        pressKey(6'd2, 3'b000);
        checkOutput("done_reject", bet_reject, 1'b1);
        pressKey(6'd8, 3'b110);
        checkOutput("new_round_count", bet_count, 4'd1);
        checkOutput("new_round_entry", bets[7:0], 8'h88);

        // Reset in the middle of a spin
        pressKey(OP_CLEAR, 3'd0);
        for (int i = 0; i < 5; i++) pressKey(6'(i + 10), 3'b111);
        pressKey(OP_SPIN, 3'd0);
        applyStimulus(1'b1, 1'b1, 8'h16, 6'd1, 3'b001, 1'b0);
        checkOutput("reset_spin_count", bet_count, 4'd0);
        checkOutput("reset_spin_flag", spinning, 1'b0);
        pressKey(6'd20, 3'b010);
        checkOutput("after_reset_entry", bets[7:0], {2'b10, 6'd20});

        // Randomized traffic including prefixes, back-to-back bytes and resets
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 9);
            rb = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom_range(1, 200));
            sel = $urandom_range(0, 15);
            rop = (sel == 0) ? OP_SPIN : (sel == 1) ? OP_NONE :
                  (sel == 2) ? OP_CLEAR : 6'($urandom_range(0, 60));
            rcol = 3'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                          rb, rop, rcol, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
